// File: rtl/pipe_shifter_alu.sv
// rtl/pipe_shifter_alu.sv - pipelined shift/rotate unit, one registered stage per amount bit
// Rotates (op 100/101) exist only when SHIFTER_ROTATE_EN is defined.
module pipe_shifter_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic [SHW-1:0]   imm_amt,
    input  logic [SHW-1:0]   var_amt,
    input  logic             var_sel,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    // Index 0 is the capture register; index k+1 holds the result of shift stage k.
    logic             st_valid   [0:SHW];
    logic [WIDTH-1:0] st_data    [0:SHW];
    logic             st_carry   [0:SHW];
    logic             st_illegal [0:SHW];
    logic [TAG_W-1:0] st_tag     [0:SHW];
    logic [2:0]       st_op      [0:SHW-1];
    logic [SHW-1:0]   st_amt     [0:SHW-1];

    logic             accept;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   left_idx;
    logic [SHW-1:0]   right_idx;
    logic             legal;
    logic             cap_carry;
    logic [WIDTH-1:0] cap_data;

    assign out_valid   = st_valid[SHW];
    assign out_result  = st_data[SHW];
    assign out_carry   = st_carry[SHW];
    assign out_illegal = st_illegal[SHW];
    assign out_tag     = st_tag[SHW];
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [2:0] o,
                                                     input int k);
        int n;
        logic [WIDTH-1:0] r;
        n = 1 << k;
        r = d;
        case (o)
            3'b000:  r = d << n;
            3'b001:  r = d >> n;
            3'b011:  r = $unsigned($signed(d) >>> n);
`ifdef SHIFTER_ROTATE_EN
            3'b100:  r = (d << n) | (d >> (WIDTH - n));
            3'b101:  r = (d >> n) | (d << (WIDTH - n));
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Carry is resolved from the unshifted operand: ROL's result[0] equals SLL's
    // outgoing bit, ROR's result[MSB] equals SRL's, so only two indices are needed.
    always_comb begin
        amt       = var_sel ? var_amt : imm_amt;
        left_idx  = SHW'(0) - amt;
        right_idx = amt - SHW'(1);
        legal     = 1'b0;
        cap_carry = 1'b0;
        case (op)
            3'b000: begin legal = 1'b1; cap_carry = operand[left_idx];  end
            3'b001: begin legal = 1'b1; cap_carry = operand[right_idx]; end
            3'b011: begin legal = 1'b1; cap_carry = operand[right_idx]; end
`ifdef SHIFTER_ROTATE_EN
            3'b100: begin legal = 1'b1; cap_carry = operand[left_idx];  end
            3'b101: begin legal = 1'b1; cap_carry = operand[right_idx]; end
`endif
            default: begin legal = 1'b0; cap_carry = 1'b0; end
        endcase
        if (amt == '0) begin
            cap_carry = 1'b0;
        end
        // Illegal ops travel as zero data, which every stage leaves at zero.
        cap_data = legal ? operand : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= SHW; i++) begin
                st_valid[i]   <= 1'b0;
                st_data[i]    <= '0;
                st_carry[i]   <= 1'b0;
                st_illegal[i] <= 1'b0;
                st_tag[i]     <= '0;
            end
            for (int i = 0; i < SHW; i++) begin
                st_op[i]  <= '0;
                st_amt[i] <= '0;
            end
        end else if (in_ready) begin
            st_valid[0] <= in_valid;
            if (accept) begin
                st_data[0]    <= cap_data;
                st_carry[0]   <= cap_carry;
                st_illegal[0] <= !legal;
                st_tag[0]     <= in_tag;
                st_op[0]      <= op;
                st_amt[0]     <= amt;
            end
            for (int k = 0; k < SHW; k++) begin
                st_valid[k+1]   <= st_valid[k];
                st_carry[k+1]   <= st_carry[k];
                st_illegal[k+1] <= st_illegal[k];
                st_tag[k+1]     <= st_tag[k];
                st_data[k+1]    <= st_amt[k][k] ? stage_shift(st_data[k], st_op[k], k)
                                                : st_data[k];
            end
            for (int k = 0; k < SHW - 1; k++) begin
                st_op[k+1]  <= st_op[k];
                st_amt[k+1] <= st_amt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipe_shifter_alu.sv
// tb/tb_pipe_shifter_alu.sv - directed self-checking bench for pipe_shifter_alu (WIDTH=32)
module tb_pipe_shifter_alu;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand;
    logic [SHW-1:0]   imm_amt;
    logic [SHW-1:0]   var_amt;
    logic             var_sel;
    logic [2:0]       op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_carry;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    pipe_shifter_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand    (operand),
        .imm_amt    (imm_amt),
        .var_amt    (var_amt),
        .var_sel    (var_sel),
        .op         (op),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_illegal(out_illegal),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [4:0] imm,
                         input logic [4:0] va, input logic sel, input logic [3:0] t);
        op       = o;
        operand  = d;
        imm_amt  = imm;
        var_amt  = va;
        var_sel  = sel;
        in_tag   = t;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_one(input string name, input logic [2:0] o, input logic [31:0] d,
                           input logic [4:0] imm, input logic [4:0] va, input logic sel,
                           input logic [3:0] t, input logic [31:0] exp_res,
                           input logic exp_c, input logic exp_ill);
        int lat;
        issue(o, d, imm, va, sel, t);
        wait_out(lat);
        chk({name, "_latency"}, lat, 5);
        chk({name, "_result"}, out_result, exp_res);
        chk({name, "_carry"}, out_carry, exp_c);
        chk({name, "_illegal"}, out_illegal, exp_ill);
        chk({name, "_tag"}, out_tag, t);
        tick();
    endtask

    initial begin
        int issued;
        int retired;
        int stall_left;
        int seen0;
        int vcount;
        int lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        operand   = '0;
        imm_amt   = '0;
        var_amt   = '0;
        var_sel   = 1'b0;
        op        = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result", out_result, 0);
        chk("rst_tag", out_tag, 0);
        rst_n = 1'b1;

        run_one("sll4",  3'b000, 32'h0000_00F1, 5'd4,  5'd0,  1'b0, 4'd1, 32'h0000_0F10, 1'b0, 1'b0);
        run_one("sra4",  3'b011, 32'h8000_0018, 5'd31, 5'd4,  1'b1, 4'd2, 32'hF800_0001, 1'b1, 1'b0);
        run_one("sll1c", 3'b000, 32'h8000_0001, 5'd1,  5'd0,  1'b0, 4'd3, 32'h0000_0002, 1'b1, 1'b0);
        run_one("srl31", 3'b001, 32'h8000_0000, 5'd0,  5'd31, 1'b1, 4'd4, 32'h0000_0001, 1'b0, 1'b0);
        run_one("ill010", 3'b010, 32'hFFFF_FFFF, 5'd3, 5'd0,  1'b0, 4'd5, 32'h0, 1'b0, 1'b1);
        run_one("ill111", 3'b111, 32'hFFFF_FFFF, 5'd7, 5'd0,  1'b0, 4'd6, 32'h0, 1'b0, 1'b1);
        run_one("srl0",  3'b001, 32'h0000_1234, 5'd0,  5'd0,  1'b0, 4'd7, 32'h0000_1234, 1'b0, 1'b0);
        run_one("sll0",  3'b000, 32'hFFFF_FFFF, 5'd31, 5'd0,  1'b1, 4'd8, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef SHIFTER_ROTATE_EN
        run_one("ror1",  3'b101, 32'h0000_0001, 5'd1,  5'd0,  1'b0, 4'd9, 32'h8000_0000, 1'b1, 1'b0);
        run_one("rol4",  3'b100, 32'hF000_0000, 5'd4,  5'd0,  1'b0, 4'd10, 32'h0000_000F, 1'b1, 1'b0);
`else
        run_one("ror1",  3'b101, 32'h0000_0001, 5'd1,  5'd0,  1'b0, 4'd9, 32'h0, 1'b0, 1'b1);
        run_one("rol4",  3'b100, 32'hF000_0000, 5'd4,  5'd0,  1'b0, 4'd10, 32'h0, 1'b0, 1'b1);
`endif

        // Back-to-back SLL-by-1 with a 3-cycle stall when tag 0 first reaches the output.
        issued     = 0;
        retired    = 0;
        stall_left = 0;
        seen0      = 0;
        op         = 3'b000;
        imm_amt    = 5'd1;
        var_sel    = 1'b0;
        for (int cyc = 0; cyc < 60 && retired < 8; cyc++) begin
            in_valid = (issued < 8);
            operand  = issued + 1;
            in_tag   = issued[3:0];
            if (out_valid && seen0 == 0) begin
                seen0      = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_frozen_tag", out_tag, 0);
                chk("bp_frozen_result", out_result, 2);
            end
            if (out_valid && out_ready) begin
                chk("bp_order_tag", out_tag, retired);
                chk("bp_result", out_result, 2 * (retired + 1));
                retired++;
            end
            if (in_valid && in_ready) issued++;
            if (stall_left > 0) stall_left--;
            tick();
        end
        chk("bp_retired", retired, 8);
        chk("bp_stall_seen", seen0, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // Reset while three ops are in flight; in_valid stays high during reset.
        op       = 3'b000;
        imm_amt  = 5'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            operand = 32'h10 + i;
            in_tag  = 4'hA + i[3:0];
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", out_result, 0);
        chk("mid_rst_tag", out_tag, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        vcount   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        chk("mid_rst_no_valid", vcount, 0);
        issue(3'b001, 32'h0000_0100, 5'd8, 5'd0, 1'b0, 4'd9);
        wait_out(lat);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_result", out_result, 32'h1);
        chk("post_rst_carry", out_carry, 0);
        chk("post_rst_tag", out_tag, 9);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_shifter_alu.md
# pipe_shifter_alu

Parametrised, pipelined successor to the single-cycle ALU shifter. Performs logical/arithmetic shifts and rotates on a WIDTH-bit operand, with shift amount selected from an immediate or a register (variable) field. One shift stage per amount bit, each registered. Valid/ready handshake with full-pipeline stall. Sits between operand fetch and writeback in the execute stage.

## Interface
- WIDTH, 32: operand/result width; power of two, >= 8. Localparam SHW = $clog2(WIDTH).
- TAG_W, 4: width of the pass-through instruction tag.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  one clock; reset is synchronous and active-low.
- in_valid  in  1  input transaction present.
- in_ready  out  1  pipeline can accept; = !out_valid || out_ready.
- operand  in  WIDTH  value to shift.
- imm_amt  in  SHW  immediate shift amount.
- var_amt  in  SHW  register-sourced shift amount.
- var_sel  in  1  1: use var_amt; 0: use imm_amt.
- op  in  3  operation code (see Operation).
- in_tag  in  TAG_W  tag carried unchanged to output.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  shifted value.
- out_carry  out  1  last bit shifted or rotated out.
- out_illegal  out  1  op was unsupported.
- out_tag  out  TAG_W  tag of the transaction.

## Operation
- Accept when in_valid && in_ready (in_ready driven low only by output stall). Inputs sampled only on accept.
- amt = var_sel ? var_amt : imm_amt; amount 0 gives result = operand, carry 0.
- op: 000 SLL; 001 SRL; 011 SRA (fill with operand[WIDTH-1]); 100 ROL; 101 ROR; 010, 110, 111 illegal.
- Illegal op: result 0, carry 0, out_illegal 1; tag still propagated.
- Carry (computed at accept, piped with data): SLL operand[WIDTH-amt]; SRL/SRA operand[amt-1]; ROL result[0]; ROR result[WIDTH-1]; 0 when amt = 0.
- Stage k (k = 0..SHW-1) applies shift/rotate by 2^k when amt[k] set; each stage registers data, remaining amount bits, op class, carry, illegal, tag, valid.
- Bubbles travel as valid=0 stages; no reordering.

## Timing
- Latency: exactly SHW cycles from accept edge to out_valid (5 at WIDTH=32). Throughput 1 per cycle.
- Stall: out_valid && !out_ready freezes every stage, including bubbles; in_ready low in same cycle (combinational).
- out_valid && out_ready with in_valid: accept and retire same cycle; no throughput loss.
- Reset (rst_n low at edge): all stage valids 0; out_result, out_carry, out_illegal, out_tag = 0; out_valid = 0. In-flight transactions discarded; in_valid ignored while rst_n low. First accept possible on first edge with rst_n high.
- Outputs stable while out_valid && !out_ready.

## Configuration
- SHIFTER_ROTATE_EN defined: ROL/ROR (100, 101) implemented as above.
- Not defined: 100 and 101 treated as illegal (result 0, carry 0, out_illegal 1); rotate muxing removed from all stages. Latency unchanged.

## Test plan
- SLL: operand 0x000000F1, imm_amt 4, var_sel 0, tag 1 -> 5 cycles later result 0x00000F10, carry 0, tag 1.
- SRA: operand 0x80000018, var_amt 4, imm_amt 31, var_sel 1 -> result 0xF8000001, carry 1.
- ROR (macro defined): operand 0x00000001, amt 1 -> result 0x80000000, carry 1; macro undefined -> result 0, illegal 1.
- Illegal op 010, operand 0xFFFFFFFF, amt 3 -> result 0, carry 0, illegal 1; amt 0 SRL of 0x1234 -> 0x1234, carry 0.
- Backpressure: 8 back-to-back SLL-by-1 ops, tags 0..7, operands 1..8; hold out_ready low 3 cycles when tag 0 appears -> outputs frozen, in_ready low, all 8 retire in order with results 2,4,..,16.
- Reset mid-operation: accept 3 ops, assert rst_n low for 1 cycle at cycle 2 -> no out_valid ever for those ops; new op accepted after release appears SHW cycles later.
